// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port and the data port. Fixed data priority with a
// starvation override for fetch; each access runs IDLE -> ISSUE -> WAIT -> DONE.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned LAT        = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    // fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic          gnt_q;       // 1 = data port owns the access, 0 = fetch
    logic          we_q;        // store in flight (no read capture)
    logic [CW-1:0] starve_q;
    logic [CW-1:0] wait_q;
    logic          if_ack_q;
    logic          d_ack_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic          starved_c;
    logic          grant_data_c;

    // Data wins a contested grant unless fetch has lost STARVE_MAX times in a row
    assign starved_c    = (starve_q == CW'(STARVE_MAX));
    assign grant_data_c = d_req & ~(if_req & starved_c);

    // Access sequencer with registered memory strobes, acks and read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            starve_q    <= '0;
            wait_q      <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        gnt_q       <= grant_data_c;
                        we_q        <= grant_data_c & d_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_data_c & d_we;
                        mem_addr_q  <= grant_data_c ? d_addr : if_addr;
                        mem_wdata_q <= d_wdata;
                        if (!grant_data_c) begin
                            starve_q <= '0;
                        end else if (if_req && !starved_c) begin
                            starve_q <= starve_q + CW'(1);
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    wait_q   <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (wait_q == CW'(LAT - 1)) begin
                        if (!we_q) begin
                            if (gnt_q) d_rdata_q  <= mem_rdata;
                            else       if_rdata_q <= mem_rdata;
                        end
                        if (gnt_q) d_ack_q  <= 1'b1;
                        else       if_ack_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Stalls track the live requests so the core freezes in the request cycle
    assign if_stall = if_req & ~if_ack_q;
    assign d_stall  = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: one instance at LAT=1/STARVE_MAX=2,
// one at LAT=3 for the long-latency load case.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    // instance A: LAT=1, STARVE_MAX=2
    logic        a_if_req, a_if_ack, a_if_stall;
    logic [31:0] a_if_addr, a_if_rdata;
    logic        a_d_req, a_d_we, a_d_ack, a_d_stall;
    logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // instance B: LAT=3
    logic        b_if_req, b_if_ack, b_if_stall;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_ack, b_d_stall;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE_MAX(2)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack),
        .if_rdata(a_if_rdata), .if_stall(a_if_stall),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata), .d_stall(a_d_stall),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack),
        .if_rdata(b_if_rdata), .if_stall(b_if_stall),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata), .d_stall(b_d_stall),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // start of a new cycle: inputs are driven right after this
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sampling point of the current cycle
    task automatic mid();
        @(negedge clk);
    endtask

    logic [5:0] order;
    int         nacks;
    int         activity;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
        a_mem_rdata = '0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
        b_mem_rdata = '0;

        // reset state
        tick();
        check_eq("rst_mem_en", a_mem_en, 0);
        check_eq("rst_if_ack", a_if_ack, 0);
        check_eq("rst_d_ack", a_d_ack, 0);
        check_eq("rst_if_rdata", a_if_rdata, 0);
        tick();
        reset = 1'b0;

        // 1: single fetch, LAT=1
        tick();
        a_if_req = 1; a_if_addr = 32'h100; a_mem_rdata = 32'hE3A00001;
        mid();
        check_eq("f_c0_stall", a_if_stall, 1);
        check_eq("f_c0_mem_en", a_mem_en, 0);
        tick(); mid();
        check_eq("f_c1_mem_en", a_mem_en, 1);
        check_eq("f_c1_mem_we", a_mem_we, 0);
        check_eq("f_c1_mem_addr", a_mem_addr, 32'h100);
        check_eq("f_c1_stall", a_if_stall, 1);
        tick(); mid();
        check_eq("f_c2_mem_en", a_mem_en, 0);
        check_eq("f_c2_if_ack", a_if_ack, 0);
        check_eq("f_c2_stall", a_if_stall, 1);
        tick(); mid();
        check_eq("f_c3_if_ack", a_if_ack, 1);
        check_eq("f_c3_if_rdata", a_if_rdata, 32'hE3A00001);
        check_eq("f_c3_stall", a_if_stall, 0);
        tick();
        a_if_req = 0;
        mid();
        check_eq("f_c4_if_ack", a_if_ack, 0);

        // 2: contested fetch + store, data first
        tick();
        a_if_req = 1; a_if_addr = 32'h104;
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h200; a_d_wdata = 32'hDEADBEEF;
        a_mem_rdata = 32'hE1A00000;
        mid();
        check_eq("c_c0_d_stall", a_d_stall, 1);
        tick(); mid();
        check_eq("c_c1_mem_en", a_mem_en, 1);
        check_eq("c_c1_mem_we", a_mem_we, 1);
        check_eq("c_c1_mem_addr", a_mem_addr, 32'h200);
        check_eq("c_c1_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
        tick(); mid();
        check_eq("c_c2_mem_we", a_mem_we, 0);
        tick(); mid();
        check_eq("c_c3_d_ack", a_d_ack, 1);
        check_eq("c_c3_if_ack", a_if_ack, 0);
        check_eq("c_c3_d_stall", a_d_stall, 0);
        check_eq("c_c3_if_stall", a_if_stall, 1);
        tick();
        a_d_req = 0;
        mid();
        check_eq("c_c4_mem_en", a_mem_en, 0);
        tick(); mid();
        check_eq("c_c5_mem_en", a_mem_en, 1);
        check_eq("c_c5_mem_addr", a_mem_addr, 32'h104);
        check_eq("c_c5_mem_we", a_mem_we, 0);
        tick(); mid();
        tick(); mid();
        check_eq("c_c7_if_ack", a_if_ack, 1);
        check_eq("c_c7_if_rdata", a_if_rdata, 32'hE1A00000);
        check_eq("c_c7_d_rdata", a_d_rdata, 0);
        tick();
        a_if_req = 0;

        // 3: both held high, STARVE_MAX=2 -> D D I D D I
        tick();
        a_if_req = 1; a_if_addr = 32'h108;
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h204;
        order = '0;
        nacks = 0;
        for (int c = 0; c < 60 && nacks < 6; c++) begin
            mid();
            if (a_if_ack && a_d_ack) check_eq("s_ack_excl", 2'b11, 2'b00);
            if (a_d_ack) begin order = {order[4:0], 1'b1}; nacks++; end
            else if (a_if_ack) begin order = {order[4:0], 1'b0}; nacks++; end
        end
        check_eq("s_ack_count", 64'(nacks), 6);
        check_eq("s_grant_order", order, 6'b110110);
        tick();
        a_if_req = 0; a_d_req = 0;

        // 5: reset during WAIT aborts the access
        tick();
        a_if_req = 1; a_if_addr = 32'h10C; a_mem_rdata = 32'h11111111;
        tick();
        tick();
        reset = 1'b1; a_if_req = 0;
        #1;
        check_eq("r_mem_en", a_mem_en, 0);
        check_eq("r_mem_addr", a_mem_addr, 0);
        check_eq("r_if_rdata", a_if_rdata, 0);
        check_eq("r_d_rdata", a_d_rdata, 0);
        check_eq("r_if_ack", a_if_ack, 0);
        tick();
        tick();
        reset = 1'b0;
        activity = 0;
        for (int c = 0; c < 4; c++) begin
            mid();
            activity += int'(a_if_ack) + int'(a_d_ack) + int'(a_mem_en);
            tick();
        end
        check_eq("r_no_ack_after", 64'(activity), 0);
        a_if_req = 1; a_if_addr = 32'h110; a_mem_rdata = 32'hE2811001;
        tick(); mid();
        check_eq("r_new_mem_en", a_mem_en, 1);
        check_eq("r_new_mem_addr", a_mem_addr, 32'h110);
        tick(); mid();
        check_eq("r_new_c2_ack", a_if_ack, 0);
        tick(); mid();
        check_eq("r_new_if_ack", a_if_ack, 1);
        check_eq("r_new_if_rdata", a_if_rdata, 32'hE2811001);
        tick();
        a_if_req = 0;

        // 6: d_req dropped during WAIT still completes
        tick();
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h400; a_mem_rdata = 32'hCAFEF00D;
        tick();
        tick();
        a_d_req = 0;
        mid();
        check_eq("w_c2_d_stall", a_d_stall, 0);
        tick(); mid();
        check_eq("w_c3_d_ack", a_d_ack, 1);
        check_eq("w_c3_d_rdata", a_d_rdata, 32'hCAFEF00D);
        activity = 0;
        for (int c = 0; c < 4; c++) begin
            tick(); mid();
            activity += int'(a_d_ack) + int'(a_mem_en);
        end
        check_eq("w_idle_after", 64'(activity), 0);

        // 4: LAT=3 load, rdata valid only in cycle 4
        tick();
        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h300; b_mem_rdata = 32'hBAD0BAD0;
        mid();
        check_eq("l_c0_mem_en", b_mem_en, 0);
        tick(); mid();
        check_eq("l_c1_mem_en", b_mem_en, 1);
        check_eq("l_c1_mem_addr", b_mem_addr, 32'h300);
        tick(); mid();
        check_eq("l_c2_mem_en", b_mem_en, 0);
        tick(); mid();
        check_eq("l_c3_mem_en", b_mem_en, 0);
        check_eq("l_c3_d_ack", b_d_ack, 0);
        tick();
        b_mem_rdata = 32'h12345678;
        mid();
        check_eq("l_c4_d_ack", b_d_ack, 0);
        tick();
        b_mem_rdata = 32'hBAD0BAD0;
        mid();
        check_eq("l_c5_d_ack", b_d_ack, 1);
        check_eq("l_c5_d_rdata", b_d_rdata, 32'h12345678);
        tick();
        b_d_req = 0;
        mid();
        check_eq("l_c6_d_ack", b_d_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch port and the data port (LDR/STR) of the ARM core. Arbitration is fixed priority with an anti-starvation override. The block sequences each access through issue, wait and done phases, and returns a one-cycle ack plus registered read data. It sits between the core's fetch and memory stages and the unified instruction/data memory, and drives the core's stall inputs.

## Interface
- AW, 32, address width
- DW, 32, data width
- LAT, 1, memory read latency in cycles (1..7): rdata is valid LAT cycles after the cycle in which mem_en is high
- STARVE_MAX, 4, consecutive contested data grants before fetch is forced (1..7)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DW  fetched word, valid while if_ack=1, held afterwards
- if_stall  out  1  if_req & ~if_ack (combinational)
- d_req  in  1  data request; held with d_we, d_addr, d_wdata until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  load data, valid while d_ack=1; unchanged by stores
- d_stall  out  1  d_req & ~d_ack (combinational)
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  memory write enable, only ever high together with mem_en
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DW  memory write data (registered)
- mem_rdata  in  DW  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered except the stall signals.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick the grantee:
    - only one request present: grant it;
    - both present: grant data, unless starve_cnt==STARVE_MAX, in which case grant fetch.
  - Latch grantee (gnt), mem_addr, mem_we (d_we for data, 0 for fetch) and mem_wdata. Go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle. Clear wait counter. Go to WAIT.
- WAIT: mem_en=0. Count cycles.
  - At the LAT-th cycle after ISSUE, capture mem_rdata into if_rdata or d_rdata according to gnt.
  - Stores skip the capture.
  - Go to DONE.
- DONE: pulse if_ack or d_ack according to gnt. Go to IDLE.
  - The requester drops or changes req at the following edge.
  - IDLE evaluates the new req values.
- starve_cnt (3 bits):
  - increments, saturating at STARVE_MAX, on each data grant made while if_req=1;
  - clears on every fetch grant;
  - unchanged on uncontested data grants.
- Requests are not re-sampled between grant and DONE.
  - A req that drops mid-access does not abort it; the access completes and ack still pulses.
- Reset (asynchronous, any state): go to IDLE.
  - All outputs, if_rdata, d_rdata, gnt, starve_cnt and the wait counter go to 0.
  - An aborted access never produces an ack.

## Timing
- Request first seen in IDLE at cycle 0:
  - mem_en in cycle 1;
  - rdata captured at the end of cycle 1+LAT;
  - ack in cycle 2+LAT;
  - IDLE again in cycle 3+LAT.
- Access occupancy: LAT+3 cycles. Back-to-back accesses therefore issue mem_en every LAT+3 cycles.
- Stores use the same timeline; mem_we=1 only in the ISSUE cycle.
- At most one of if_ack and d_ack is high in any cycle. Each ack lasts exactly one cycle.
- Stall signals follow req combinationally. Stall is high in the request cycle and drops in the ack cycle.

## Test plan
- LAT=1, if_req with if_addr=0x100, memory returns 0xE3A00001 -> mem_en=1, mem_we=0, mem_addr=0x100 in cycle 1; if_ack=1 and if_rdata=0xE3A00001 in cycle 3; if_stall=1 in cycles 0-2.
- LAT=1, if_req (0x104) and d_req store (0x200, 0xDEADBEEF) in the same cycle -> store issued in cycle 1 with mem_we=1, mem_wdata=0xDEADBEEF; d_ack in cycle 3; fetch mem_en in cycle 5; if_ack in cycle 7; d_rdata unchanged.
- STARVE_MAX=2, d_req and if_req held high continuously (re-requested after each ack) -> grant order D, D, I, D, D, I.
- LAT=3 load from 0x300, mem_rdata=0x12345678 valid in cycle 4 -> mem_en high only in cycle 1; d_ack and d_rdata=0x12345678 in cycle 5.
- Reset asserted in WAIT -> all outputs 0 in the same cycle. After release: no ack for the aborted access, and a new fetch completes on the normal LAT+2 timeline.
- d_req dropped during WAIT -> d_ack still pulses in cycle 2+LAT; IDLE then ignores data.
